// File: rtl/bootrom_loader_pkg.sv
// Shared AHB3 constants, loader state encoding and counter sizing helper for bootrom_loader.
package bootrom_loader_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData,
    StDone,
    StError
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/bootrom_loader_fsm.sv
// Copy sequencer for bootrom_loader: state register plus word counter.
module bootrom_loader_fsm
  import bootrom_loader_pkg::*;
#(
  parameter int unsigned WORDS      = 64,
  parameter bit          AUTO_START = 1'b1,
  localparam int unsigned CW        = cnt_width(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          hready_i,
  input  logic          hresp_i,
  input  logic          sum_ok_i,
  output state_e        state_q_o,
  output state_e        state_d_o,
  output logic [CW-1:0] cnt_d_o
);

  localparam logic [CW-1:0] LastCnt = CW'(WORDS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q;
  logic          launch;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    case (state_q)
      StIdle:   launch = start_i || (AUTO_START && first_q);
      StRdAddr: if (hready_i) state_d = StRdData;
      StRdData: if (hready_i) state_d = hresp_i ? StError : StWrAddr;
      StWrAddr: if (hready_i) state_d = StWrData;
      StWrData: begin
        if (hready_i) begin
          if (hresp_i) begin
            state_d = StError;
          end else if (cnt_q == LastCnt) begin
            state_d = sum_ok_i ? StDone : StError;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StRdAddr;
          end
        end
      end
      StDone:   launch = start_i;
      StError:  state_d = StError;
      default:  state_d = StIdle;
    endcase
    if (launch) begin
      state_d = StRdAddr;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= 1'b0;
    end
  end

  assign state_q_o = state_q;
  assign state_d_o = state_d;
  assign cnt_d_o   = cnt_d;

endmodule

// File: rtl/bootrom_loader.sv
// AHB3 master copying the boot image from ROM to RAM, then releasing the core reset.
// Optional checksum gate enabled by defining BOOTROM_LOADER_CHECKSUM_EN.
module bootrom_loader
  import bootrom_loader_pkg::*;
#(
  parameter int unsigned     PLEN         = 32,
  parameter int unsigned     XLEN         = 32,
  parameter logic [PLEN-1:0] ROM_BASE     = 32'h0000_0000,
  parameter logic [PLEN-1:0] RAM_BASE     = 32'h8000_0000,
  parameter int unsigned     WORDS        = 64,
  parameter bit              AUTO_START   = 1'b1,
  parameter logic [31:0]     EXPECTED_SUM = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic            cpu_rst_o,
`ifdef BOOTROM_LOADER_CHECKSUM_EN
  output logic [31:0]     checksum_o,
`endif
  output logic            ahb3_hsel_o,
  output logic [PLEN-1:0] ahb3_haddr_o,
  output logic [XLEN-1:0] ahb3_hwdata_o,
  input  logic [XLEN-1:0] ahb3_hrdata_i,
  output logic            ahb3_hwrite_o,
  output logic [2:0]      ahb3_hsize_o,
  output logic [2:0]      ahb3_hburst_o,
  output logic [3:0]      ahb3_hprot_o,
  output logic [1:0]      ahb3_htrans_o,
  output logic            ahb3_hmastlock_o,
  input  logic            ahb3_hready_i,
  input  logic            ahb3_hresp_i
);

  localparam int unsigned CW = cnt_width(WORDS);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_d;
  logic            sum_ok;
  logic            addr_phase;
  logic            capture;
  logic [PLEN-1:0] next_addr;

  logic            hsel_q, hwrite_q;
  logic [1:0]      htrans_q;
  logic [PLEN-1:0] haddr_q;
  logic [XLEN-1:0] buf_q;
  logic            busy_q, done_q, error_q, cpu_rst_q;

  bootrom_loader_fsm #(
    .WORDS      (WORDS),
    .AUTO_START (AUTO_START)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .hready_i  (ahb3_hready_i),
    .hresp_i   (ahb3_hresp_i),
    .sum_ok_i  (sum_ok),
    .state_q_o (state_q),
    .state_d_o (state_d),
    .cnt_d_o   (cnt_d)
  );

  assign addr_phase = (state_d == StRdAddr) || (state_d == StWrAddr);
  assign capture    = (state_q == StRdData) && ahb3_hready_i && !ahb3_hresp_i;
  assign next_addr  = ((state_d == StWrAddr) ? RAM_BASE : ROM_BASE) + (PLEN'(cnt_d) << 2);

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsel_q    <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      buf_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      hsel_q    <= addr_phase;
      htrans_q  <= addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
      hwrite_q  <= (state_d == StWrAddr) || (state_d == StWrData);
      busy_q    <= state_d inside {StRdAddr, StRdData, StWrAddr, StWrData};
      done_q    <= (state_d == StDone);
      error_q   <= (state_d == StError);
      cpu_rst_q <= (state_d != StDone);
      if (addr_phase) haddr_q <= next_addr;
      if (capture) buf_q <= ahb3_hrdata_i;
    end
  end

`ifdef BOOTROM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        copy_start;

  assign copy_start = (state_d == StRdAddr) && ((state_q == StIdle) || (state_q == StDone));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (copy_start) begin
      sum_q <= '0;
    end else if (capture) begin
      sum_q <= sum_q + 32'(ahb3_hrdata_i);
    end
  end

  assign sum_ok     = (sum_q == EXPECTED_SUM);
  assign checksum_o = sum_q;
`else
  logic unused_expected_sum;
  assign unused_expected_sum = ^EXPECTED_SUM;
  assign sum_ok              = 1'b1;
`endif

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign cpu_rst_o        = cpu_rst_q;
  assign ahb3_hsel_o      = hsel_q;
  assign ahb3_haddr_o     = haddr_q;
  assign ahb3_hwdata_o    = buf_q;
  assign ahb3_hwrite_o    = hwrite_q;
  assign ahb3_htrans_o    = htrans_q;
  assign ahb3_hsize_o     = HSIZE_WORD;
  assign ahb3_hburst_o    = HBURST_SINGLE;
  assign ahb3_hprot_o     = HPROT_DEFAULT;
  assign ahb3_hmastlock_o = 1'b0;

endmodule

// File: tb/tb_bootrom_loader.sv
// Self-checking bench for bootrom_loader: AHB slave model with ROM image and RAM write log,
// per-cycle bus expectations derived from the word/phase position of the copy.
module tb_bootrom_loader;

  localparam int          W       = 4;
  localparam logic [31:0] ROM_B   = 32'h0000_0000;
  localparam logic [31:0] RAM_B   = 32'h8000_0000;
  localparam logic [31:0] EXP_SUM = 32'h0000_00AA;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic        busy, done, error, cpu_rst, hsel, hwrite, hmastlock;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
`ifdef BOOTROM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rom [W];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic        dp_valid, dp_write;
  logic [31:0] dp_addr;

  always #5 clk = ~clk;

  bootrom_loader #(
    .WORDS        (W),
    .AUTO_START   (1'b1),
    .EXPECTED_SUM (EXP_SUM)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .cpu_rst_o        (cpu_rst),
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    .checksum_o       (checksum),
`endif
    .ahb3_hsel_o      (hsel),
    .ahb3_haddr_o     (haddr),
    .ahb3_hwdata_o    (hwdata),
    .ahb3_hrdata_i    (hrdata),
    .ahb3_hwrite_o    (hwrite),
    .ahb3_hsize_o     (hsize),
    .ahb3_hburst_o    (hburst),
    .ahb3_hprot_o     (hprot),
    .ahb3_htrans_o    (htrans),
    .ahb3_hmastlock_o (hmastlock),
    .ahb3_hready_i    (hready),
    .ahb3_hresp_i     (hresp)
  );

  // Slave: latch the address phase, serve ROM reads, log completed RAM writes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (hready) begin
      if (dp_valid && dp_write && !hresp) begin
        wr_addr_q.push_back(dp_addr);
        wr_data_q.push_back(hwdata);
      end
      dp_valid <= hsel && (htrans == 2'b10);
      dp_write <= hwrite;
      dp_addr  <= haddr;
    end
  end

  assign hrdata = (dp_valid && !dp_write) ? rom[dp_addr[3:2]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_hsel"}, hsel, 0);
    check({tag, "_htrans"}, htrans, 0);
    check({tag, "_haddr"}, haddr, 0);
    check({tag, "_hwdata"}, hwdata, 0);
    check({tag, "_hwrite"}, hwrite, 0);
    check({tag, "_hsize"}, hsize, 3'b010);
    check({tag, "_hburst"}, hburst, 3'b000);
    check({tag, "_hprot"}, hprot, 4'b0011);
    check({tag, "_hmastlock"}, hmastlock, 0);
  endtask

  // Step k of a copy: word k/4, phase k%4 = read addr, read data, write addr, write data.
  task automatic check_phase(input int k);
    int w = k / 4;
    int ph = k % 4;
    check($sformatf("busy@k%0d", k), busy, 1);
    check($sformatf("done@k%0d", k), done, 0);
    check($sformatf("cpu_rst@k%0d", k), cpu_rst, 1);
    check($sformatf("hsel@k%0d", k), hsel, (ph == 0 || ph == 2) ? 1 : 0);
    check($sformatf("htrans@k%0d", k), htrans, (ph == 0 || ph == 2) ? 2 : 0);
    if (ph == 0 || ph == 2) begin
      check($sformatf("hwrite@k%0d", k), hwrite, (ph == 2) ? 1 : 0);
      check($sformatf("haddr@k%0d", k), haddr, ((ph == 2) ? RAM_B : ROM_B) + 32'(4 * w));
    end
    if (ph == 3) check($sformatf("hwdata@k%0d", k), hwdata, rom[w]);
  endtask

  task automatic fill_rom();
    logic [31:0] s = '0;
    for (int i = 0; i < W; i++) rom[i] = $urandom;
    if (CHK) begin
      for (int i = 0; i < W - 1; i++) s += rom[i];
      rom[W-1] = EXP_SUM - s;
    end
  endtask

  task automatic do_copy(input bit use_start, input int stall_at, input int stall_len,
                         input bit rand_rdy, input int err_at, input int abort_at,
                         input int pulse_at);
    int          k = 0;
    int          held = 0;
    int          n_wr;
    bit          err_seen = 1'b0;
    bit          rdy;
    bit          sum_bad;
    logic [31:0] sum = '0;
    logic [31:0] csum = '0;
    for (int i = 0; i < W; i++) sum += rom[i];
    wr_addr_q.delete();
    wr_data_q.delete();
    if (use_start) begin
      @(negedge clk);
      start_i = 1'b1;
    end
    @(posedge clk);
    #1 start_i = 1'b0;
    while (k < 4 * W && !err_seen) begin
      @(negedge clk);
      if (k == abort_at) return;
      check_phase(k);
      if (k == pulse_at) start_i = 1'b1;
      rdy = 1'b1;
      if (k == stall_at && held < stall_len) begin
        rdy = 1'b0;
        held++;
      end else if (rand_rdy) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      hready = rdy;
      hresp  = rdy && (k == err_at);
      @(posedge clk);
      if (rdy) begin
        if (k == err_at) err_seen = 1'b1;
        k++;
      end
      #1;
      start_i = 1'b0;
      hresp   = 1'b0;
    end
    @(negedge clk);
    hready  = 1'b1;
    sum_bad = !err_seen && CHK && (sum != EXP_SUM);
    n_wr    = err_seen ? err_at / 4 : W;
    check("end_done", done, !(err_seen || sum_bad));
    check("end_error", error, err_seen || sum_bad);
    check("end_cpu_rst", cpu_rst, err_seen || sum_bad);
    check("end_busy", busy, 0);
    check("end_hsel", hsel, 0);
    check("end_nwrites", wr_addr_q.size(), n_wr);
    for (int i = 0; i < n_wr && i < wr_addr_q.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wr_addr_q[i], RAM_B + 32'(4 * i));
      check($sformatf("wr_data%0d", i), wr_data_q[i], rom[i]);
      csum += rom[i];
    end
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    check("checksum", checksum, csum);
`endif
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst0");

    // Auto-start copy of a fixed image, zero wait states.
    rom = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst = 1'b1;
    do_copy(1'b0, -1, 0, 1'b0, -1, -1, -1);

    // Restart from DONE; start pulse while busy; 3-cycle stall on read address of word 2.
    fill_rom();
    do_copy(1'b1, 8, 3, 1'b0, -1, -1, 5);

    // Random wait states.
    fill_rom();
    do_copy(1'b1, -1, 0, 1'b1, -1, -1, -1);

    // Bus error on the read of word 1; later start pulse must be ignored.
    fill_rom();
    do_copy(1'b1, -1, 0, 1'b0, 5, -1, -1);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", error, 1);
    check("err_busy", busy, 0);
    check("err_cpu_rst", cpu_rst, 1);
    check("err_hsel", hsel, 0);

    // Reset clears the error, then a copy is aborted by reset during word 3.
    rst = 1'b0;
    #1 check_reset("rst_err");
    @(negedge clk);
    rst = 1'b1;
    fill_rom();
    do_copy(1'b0, -1, 0, 1'b0, -1, 13, -1);
    rst = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    fill_rom();
    do_copy(1'b0, -1, 0, 1'b1, -1, -1, -1);

`ifdef BOOTROM_LOADER_CHECKSUM_EN
    // Image whose sum is one above the reference must end in ERROR.
    fill_rom();
    rom[0] = rom[0] + 32'd1;
    do_copy(1'b1, -1, 0, 1'b0, -1, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
